// File: rtl/fft_pkg.sv
// Shared types and index helpers for the FFT pair reorder blocks.
package fft_pkg;

  typedef logic bank_t;

  // Natural index of beat k in the pair order of the given stage.
  function automatic int pair_to_natural(int k, int stage, int log2);
    int p;
    int b;
    int h;
    p = k >> 1;
    b = k & 1;
    h = 1 << stage;
    return (((p >> stage) * 2 * h) + (p % h) + b * h) & ((1 << log2) - 1);
  endfunction

  function automatic int clamp_stage(int s, int log2);
    return (s > log2 - 1) ? log2 - 1 : s;
  endfunction

endpackage

// File: rtl/fft_pair_addr_gen.sv
// Beat number + stage -> natural sample address (pair order).
module fft_pair_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2 = 3
) (
  input  logic [LOG2-1:0] k_i,
  input  logic [LOG2-1:0] stage_i,
  output logic [LOG2-1:0] addr_o
);

  assign addr_o = LOG2'(pair_to_natural(int'(k_i), int'(stage_i), LOG2));

endmodule

// File: rtl/fft_pair_unshuffle.sv
// Ping-pong buffer restoring natural order after the butterfly stage.
// Optional frame check: define FFT_PAIR_UNSHUFFLE_FRAMECHK_EN.
module fft_pair_unshuffle
  import fft_pkg::*;
#(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3,
  localparam int LOG2   = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2-1:0]  in_stage,
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
  input  logic             in_last,
  output logic             frame_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LOG2-1:0]  out_index,
  output logic             out_last
);

  localparam logic [LOG2-1:0] LAST = LOG2'(SAMPLES - 1);

  logic [WIDTH-1:0] mem_q [2][SAMPLES];

  bank_t           wr_bank_q, wr_bank_d;
  bank_t           rd_bank_q, rd_bank_d;
  logic [LOG2-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic [LOG2-1:0] stage_q, stage_d;
  logic [1:0]      full_q, full_d;

  logic [LOG2-1:0] in_stage_c;
  logic [LOG2-1:0] cur_stage;
  logic [LOG2-1:0] wr_addr;
  logic            wr_fire, rd_fire;
  logic            wr_last, rd_last;

  assign in_stage_c = LOG2'(clamp_stage(int'(in_stage), LOG2));
  // First beat must use the live stage; the latch only lands next cycle.
  assign cur_stage  = (wr_cnt_q == '0) ? in_stage_c : stage_q;

  fft_pair_addr_gen #(
    .LOG2(LOG2)
  ) u_addr (
    .k_i    (wr_cnt_q),
    .stage_i(cur_stage),
    .addr_o (wr_addr)
  );

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_data  = mem_q[rd_bank_q][rd_cnt_q];
  assign out_index = rd_cnt_q;
  assign out_last  = out_valid && (rd_cnt_q == LAST);

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign wr_last = (wr_cnt_q == LAST);
  assign rd_last = (rd_cnt_q == LAST);

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    stage_d   = stage_q;
    full_d    = full_q;
    if (wr_fire) begin
      if (wr_cnt_q == '0) stage_d = in_stage_c;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      stage_q   <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      stage_q   <= stage_d;
      full_q    <= full_d;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_addr] <= in_data;
  end

`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
  logic frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else if (wr_fire && (in_last != wr_last)) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_fft_pair_unshuffle.sv
// Random-data bench for fft_pair_unshuffle against a frame-level model.
// Also exercises the optional frame check when its macro is defined.
module tb_fft_pair_unshuffle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic [2:0] in_stage;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic [2:0] out_index;
  logic       out_last;
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
  logic       in_last;
  logic       frame_err;
  logic       err_m;
`endif

  fft_pair_unshuffle #(
    .SAMPLES(8),
    .WIDTH  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_stage (in_stage),
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
    .in_last  (in_last),
    .frame_err(frame_err),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] d;
    logic [2:0] st;
    logic       last;
  } beat_t;

  typedef struct {
    logic [2:0] d;
    int         idx;
  } exp_t;

  beat_t in_q[$];
  exp_t  exp_q[$];
  int    nfull;
  int    in_cnt;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Build one frame: natural-order samples, sent in pair order.
  task automatic add_frame(input int s, input bit ramp, input int bad_last);
    logic [2:0] nat[8];
    int order[$];
    int hs;
    int h;
    hs = (s > 2) ? 2 : s;
    h  = 1 << hs;
    for (int i = 0; i < 8; i++) begin
      nat[i] = ramp ? 3'(i) : 3'($urandom_range(0, 7));
      exp_q.push_back('{nat[i], i});
    end
    for (int l = 0; l < 8; l += 2 * h)
      for (int j = 0; j < h; j++) begin
        order.push_back(l + j);
        order.push_back(l + j + h);
      end
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.d    = nat[order[k]];
      b.st   = (k == 0) ? 3'(s) : 3'($urandom_range(0, 7));
      b.last = (bad_last >= 0) ? (k == bad_last) : (k == 7);
      in_q.push_back(b);
    end
  endtask

  task automatic step();
    bit fin;
    bit fout;
    bit blast;
    blast = 1'b0;
    if (in_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = in_q[0].d;
      in_stage = in_q[0].st;
      blast    = in_q[0].last;
    end else begin
      in_valid = 1'b0;
      in_data  = 3'($urandom_range(0, 7));
    end
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
    in_last = blast;
    chk("frame_err", frame_err, err_m);
`endif
    chk("in_ready", in_ready, nfull < 2);
    chk("out_valid", out_valid, nfull > 0);
    if (out_valid && exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0].d);
      chk("out_index", out_index, exp_q[0].idx);
      chk("out_last", out_last, exp_q[0].idx == 7);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (fin) begin
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
      if (blast != (in_cnt == 7)) err_m = 1'b1;
`endif
      void'(in_q.pop_front());
      in_cnt++;
      if (in_cnt == 8) begin
        in_cnt = 0;
        nfull++;
      end
    end
    if (fout) begin
      if (exp_q[0].idx == 7) nfull--;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic run_done(input int max, input bit rnd_ready);
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < max) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("drain_timeout", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_index", out_index, 0);
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
    chk("rst_frame_err", frame_err, 0);
    err_m = 1'b0;
`endif
    in_q.delete();
    exp_q.delete();
    nfull  = 0;
    in_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_stage  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
    in_last = 1'b0;
    err_m   = 1'b0;
`endif
    #2;
    do_reset();

    add_frame(0, 1'b1, -1);
    run_done(40, 1'b0);
    add_frame(1, 1'b1, -1);
    run_done(40, 1'b0);
    add_frame(2, 1'b1, -1);
    run_done(40, 1'b0);
    add_frame(7, 1'b0, -1);
    run_done(40, 1'b0);

    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) add_frame(2, 1'b0, -1);
    for (int i = 0; i < 20; i++) step();
    chk("stall_pending", in_q.size(), 8);
    out_ready = 1'b1;
    run_done(80, 1'b0);

    add_frame(1, 1'b0, -1);
    for (int i = 0; i < 5; i++) step();
    do_reset();
    add_frame(1, 1'b1, -1);
    run_done(40, 1'b0);

    for (int f = 0; f < 5; f++) add_frame(int'($urandom_range(0, 3)), 1'b0, -1);
    run_done(400, 1'b1);
    out_ready = 1'b1;

`ifdef FFT_PAIR_UNSHUFFLE_FRAMECHK_EN
    add_frame(2, 1'b0, 5);
    add_frame(1, 1'b0, -1);
    add_frame(0, 1'b0, -1);
    run_done(80, 1'b0);
    chk("err_sticky", frame_err, 1);
    do_reset();
    add_frame(0, 1'b0, -1);
    run_done(40, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
